// File: rtl/mac_dot_seq_if.sv
// Bundle of the job, operand-stream and MAC-side signals of the dot-product sequencer.
// master: host plus MAC datapath. slave: the sequencer.
interface mac_dot_seq_if #(
    parameter int unsigned LEN_W = 5,
    parameter int unsigned EXT_W = 4
);
    logic                   start;
    logic [LEN_W-1:0]       len;
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             in_a;
    logic [3:0]             in_b;
    logic [3:0]             mac_a;
    logic [3:0]             mac_b;
    logic                   mac_cin;
    logic                   mac_clr;
    logic [7:0]             mac_result;
    logic                   mac_cout;
    logic                   busy;
    logic                   done;
    logic [8+EXT_W-1:0]     result;
    logic                   ovf;

    modport master (
        output start, len, in_valid, in_a, in_b, mac_result, mac_cout,
        input  in_ready, mac_a, mac_b, mac_cin, mac_clr, busy, done, result, ovf
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, mac_result, mac_cout,
        output in_ready, mac_a, mac_b, mac_cin, mac_clr, busy, done, result, ovf
    );
endinterface

// File: rtl/mac_dot_seq.sv
// Sequencer for a 4-bit accumulating MAC: clears the MAC, streams operand pairs into it,
// widens the 8-bit accumulator by counting adder carry-outs and returns the dot product.
module mac_dot_seq #(
    parameter int unsigned LEN_W = 5,
    parameter int unsigned EXT_W = 4
) (
    input logic           clk,
    input logic           rst,
    mac_dot_seq_if.slave  bus
);
    localparam int unsigned RES_W = 8 + EXT_W;

    typedef enum logic [1:0] {StIdle, StClear, StRun, StCapture} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [EXT_W-1:0]   ext_q, ext_d;
    logic               ovf_q, ovf_d;
    logic               clr_q, clr_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   result_q, result_d;

    logic               accept;
    logic [LEN_W-1:0]   cnt_inc;
    logic [EXT_W:0]     ext_sum;

    assign accept  = (state_q == StRun) && bus.in_valid;
    assign cnt_inc = cnt_q + 1'b1;
    // The carry is counted on the same edge the MAC registers the sum that produced it.
    assign ext_sum = {1'b0, ext_q} + {{EXT_W{1'b0}}, bus.mac_cout};

    // Next-state and register update decisions.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        ext_d    = ext_q;
        ovf_d    = ovf_q;
        clr_d    = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    cnt_d   = '0;
                    ext_d   = '0;
                    ovf_d   = 1'b0;
                    clr_d   = 1'b1;
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = (len_q != '0) ? StRun : StCapture;
            end
            StRun: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    ext_d = ext_sum[EXT_W-1:0];
                    if (ext_sum[EXT_W]) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_inc == len_q) begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                result_d = {ext_q, bus.mac_result};
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any partial job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            len_q    <= '0;
            cnt_q    <= '0;
            ext_q    <= '0;
            ovf_q    <= 1'b0;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            ext_q    <= ext_d;
            ovf_q    <= ovf_d;
            clr_q    <= clr_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Operand steering: zero operands make the MAC hold its value.
    always_comb begin
        bus.mac_a = 4'd0;
        bus.mac_b = 4'd0;
        if (accept) begin
            bus.mac_a = bus.in_a;
            bus.mac_b = bus.in_b;
        end
    end

    assign bus.in_ready = (state_q == StRun);
    assign bus.mac_cin  = 1'b0;
    assign bus.mac_clr  = clr_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural 4-bit accumulating MAC attached.
module tb_mac_dot_seq;
    localparam int unsigned LEN_W = 5;
    localparam int unsigned EXT_W = 4;
    localparam int unsigned RES_W = 8 + EXT_W;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_dot_seq_if #(.LEN_W(LEN_W), .EXT_W(EXT_W)) bus ();

    mac_dot_seq #(.LEN_W(LEN_W), .EXT_W(EXT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural MAC: 4x4 multiply, 8-bit add with carry-out, result register cleared by
    // rst or mac_clr.
    logic [7:0] acc;
    logic [7:0] prod;
    logic [8:0] mac_sum;
    logic       mac_rst;
    assign prod    = 8'(bus.mac_a) * 8'(bus.mac_b);
    assign mac_sum = {1'b0, acc} + {1'b0, prod} + {8'd0, bus.mac_cin};
    assign mac_rst = rst | bus.mac_clr;
    always @(posedge clk or posedge mac_rst) begin
        if (mac_rst) acc <= 8'd0;
        else         acc <= mac_sum[7:0];
    end
    assign bus.mac_result = acc;
    assign bus.mac_cout   = mac_sum[8];

    int clr_cycles = 0;
    always @(negedge clk) if (bus.mac_clr === 1'b1) clr_cycles <= clr_cycles + 1;

    logic [3:0] va [32];
    logic [3:0] vb [32];
    int s_cyc;
    int gap_after = -1;
    int gap_len = 0;
    int gap_seen;
    int gap_bad;

    int             at;
    logic [RES_W-1:0] res;
    logic           ov;
    bit             seen;

    task automatic start_job(input int l, input bit hold);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l[LEN_W-1:0];
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic feed(input int n);
        int idx = 0;
        int guard = 0;
        bit acc_now;
        gap_seen = 0;
        gap_bad  = 0;
        while (idx < n && guard < 200) begin
            if (idx == gap_after && gap_seen < gap_len && bus.in_ready) begin
                bus.in_valid = 1'b0;
                bus.in_a     = 4'hF;
                bus.in_b     = 4'hF;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_a     = va[idx];
                bus.in_b     = vb[idx];
            end
            #1;
            if (!bus.in_valid && bus.in_ready) begin
                gap_seen++;
                if (bus.mac_a !== 4'd0 || bus.mac_b !== 4'd0) gap_bad++;
            end
            acc_now = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (acc_now) idx++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.in_a     = 4'd0;
        bus.in_b     = 4'd0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (bus.done !== 1'b1 && g < 60) begin
            @(negedge clk);
            g++;
        end
        seen = (bus.done === 1'b1);
        at   = cyc - s_cyc + 1;
        res  = bus.result;
        ov   = bus.ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_a = 4'd0; bus.in_b = 4'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.in_ready, bus.ovf, bus.mac_clr, bus.mac_cin} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000",
                     {bus.busy, bus.done, bus.in_ready, bus.ovf, bus.mac_clr, bus.mac_cin});
        else n_pass++;
        n_checks++;
        if (bus.result !== 12'd0) $display("FAIL reset_result got %h want 000", bus.result);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        va[0] = 4'd3;  vb[0] = 4'd5;
        va[1] = 4'd2;  vb[1] = 4'd7;
        va[2] = 4'd15; vb[2] = 4'd15;
        va[3] = 4'd1;  vb[3] = 4'd1;
        gap_after = -1;
        start_job(4, 1'b0);
        n_checks++;
        if ({bus.busy, bus.mac_clr, bus.in_ready} !== 3'b110)
            $display("FAIL basic_clear_cycle got %b want 110", {bus.busy, bus.mac_clr, bus.in_ready});
        else n_pass++;
        feed(4);
        wait_done();
        n_checks++;
        if (!seen || at != 7) $display("FAIL basic_latency got %0d want 7 (seen=%0d)", at, seen);
        else n_pass++;
        n_checks++;
        if (res !== 12'h0FF || ov !== 1'b0)
            $display("FAIL basic_result got %h ovf %b want 0ff ovf 0", res, ov);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 12'h0FF)
            $display("FAIL basic_after_done got done %b busy %b result %h want 0 0 0ff",
                     bus.done, bus.busy, bus.result);
        else n_pass++;
    endtask

    task automatic test_gap();
        gap_after = 2;
        gap_len   = 3;
        start_job(4, 1'b0);
        feed(4);
        gap_after = -1;
        wait_done();
        n_checks++;
        if (gap_seen != 3 || gap_bad != 0)
            $display("FAIL gap_operands got gaps %0d nonzero %0d want 3 0", gap_seen, gap_bad);
        else n_pass++;
        n_checks++;
        if (!seen || at != 10) $display("FAIL gap_latency got %0d want 10 (seen=%0d)", at, seen);
        else n_pass++;
        n_checks++;
        if (res !== 12'h0FF) $display("FAIL gap_result got %h want 0ff", res);
        else n_pass++;
    endtask

    task automatic test_len0();
        int base;
        base = clr_cycles;
        start_job(0, 1'b0);
        wait_done();
        n_checks++;
        if (!seen || at != 3) $display("FAIL len0_latency got %0d want 3 (seen=%0d)", at, seen);
        else n_pass++;
        n_checks++;
        if (res !== 12'd0) $display("FAIL len0_result got %h want 000", res);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (clr_cycles - base != 1) $display("FAIL len0_clr_pulses got %0d want 1", clr_cycles - base);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 31; i++) begin
            va[i] = 4'd15;
            vb[i] = 4'd15;
        end
        start_job(31, 1'b0);
        feed(31);
        wait_done();
        n_checks++;
        if (!seen || at != 34) $display("FAIL ovf_latency got %0d want 34 (seen=%0d)", at, seen);
        else n_pass++;
        n_checks++;
        if (res !== 12'hB3F || ov !== 1'b1)
            $display("FAIL ovf_result got %h ovf %b want b3f ovf 1", res, ov);
        else n_pass++;
        start_job(0, 1'b0);
        n_checks++;
        if (bus.ovf !== 1'b0 || bus.result !== 12'hB3F)
            $display("FAIL ovf_cleared got ovf %b result %h want 0 b3f", bus.ovf, bus.result);
        else n_pass++;
        wait_done();
    endtask

    task automatic test_mid_reset();
        va[0] = 4'd2; vb[0] = 4'd3;
        start_job(1, 1'b0);
        feed(1);
        wait_done();
        n_checks++;
        if (res !== 12'd6) $display("FAIL prereset_result got %h want 006", res);
        else n_pass++;
        va[0] = 4'd5; vb[0] = 4'd5;
        va[1] = 4'd6; vb[1] = 4'd6;
        va[2] = 4'd7; vb[2] = 4'd7;
        va[3] = 4'd8; vb[3] = 4'd8;
        start_job(4, 1'b0);
        feed(2);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.in_ready, bus.ovf, bus.mac_clr} !== 5'b0 ||
            bus.result !== 12'd0 || bus.mac_result !== 8'd0)
            $display("FAIL midreset_outputs got flags %b result %h mac %h want 0 000 00",
                     {bus.busy, bus.done, bus.in_ready, bus.ovf, bus.mac_clr}, bus.result,
                     bus.mac_result);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        va[0] = 4'd4; vb[0] = 4'd4;
        start_job(1, 1'b0);
        feed(1);
        wait_done();
        n_checks++;
        if (!seen || at != 4 || res !== 12'd16)
            $display("FAIL postreset_job got at %0d result %h want 4 010", at, res);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        va[0] = 4'd2; vb[0] = 4'd3;
        va[1] = 4'd4; vb[1] = 4'd5;
        start_job(2, 1'b1);
        bus.len = 5'd5;
        feed(2);
        bus.len = 5'd2;
        va[0] = 4'd1; vb[0] = 4'd2;
        va[1] = 4'd3; vb[1] = 4'd3;
        wait_done();
        n_checks++;
        if (!seen || at != 5 || res !== 12'd26)
            $display("FAIL b2b_job1 got at %0d result %h want 5 01a", at, res);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.mac_clr, bus.done} !== 3'b110)
            $display("FAIL b2b_accept_in_done got %b want 110", {bus.busy, bus.mac_clr, bus.done});
        else n_pass++;
        s_cyc = cyc;
        bus.start = 1'b0;
        feed(2);
        wait_done();
        n_checks++;
        if (!seen || at != 5 || res !== 12'd11)
            $display("FAIL b2b_job2 got at %0d result %h want 5 00b", at, res);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_len0();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
